puf_resp_accum: RTL

PUF_RESP_ACCUM -- requirements
Module: puf_resp_accum

---
 rtl/puf_resp_accum.sv | 110 +++++++++++
 1 files changed

// File: rtl/puf_resp_accum.sv
// Collects oscillator count pairs into a PUF response word.
// Each word carries a per-bit instability mask and a count of unstable pairs.
module puf_resp_accum #(
    parameter int CNT_W  = 8,
    parameter int RESP_W = 32,
    parameter int CW     = $clog2(RESP_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  count1,
    input  logic [CNT_W-1:0]  count2,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              mode,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic [RESP_W-1:0] resp_mask,
    output logic [CW-1:0]     unstable_cnt
);

    // The pointer can reach RESP_W itself while the word sits in HOLD.
    localparam int PW = $clog2(RESP_W + 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg;
    logic [PW-1:0]     ptr_sum;
    logic              mode_reg;
    logic              eff_mode;
    logic [RESP_W-1:0] data_reg, mask_reg;
    logic [RESP_W-1:0] bit_hit, bit_val;
    logic [CW-1:0]     cnt_reg;
    logic              accept, release_word;
    logic              winner, loser_bit, unstable;
    logic [CNT_W-1:0]  margin;

    assign accept       = in_valid && in_ready;
    assign release_word = resp_valid && resp_ready;

    // Per-pair evaluation; the margin subtracts smaller from larger so it never wraps.
    always_comb begin
        winner    = (count1 > count2);
        loser_bit = winner ? count2[0] : count1[0];
        margin    = winner ? (count1 - count2) : (count2 - count1);
        unstable  = (margin < thresh) || (count1 == count2);
        eff_mode  = (ptr_reg == '0) ? mode : mode_reg;
        ptr_sum   = ptr_reg + (eff_mode ? PW'(2) : PW'(1));
    end

    // In 2-bit mode the pointer is always even: even bit = loser, odd bit = winner.
    for (genvar gi = 0; gi < RESP_W; gi++) begin : g_bit
        assign bit_hit[gi] = (ptr_reg == PW'(gi)) ||
                             (eff_mode && ((ptr_reg + PW'(1)) == PW'(gi)));
        if (gi % 2 == 0) begin : g_even
            assign bit_val[gi] = eff_mode ? loser_bit : winner;
        end else begin : g_odd
            assign bit_val[gi] = winner;
        end
    end

    // State register plus accumulator datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
            ptr_reg   <= '0;
            mode_reg  <= 1'b0;
            data_reg  <= '0;
            mask_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (release_word) begin
                ptr_reg  <= '0;
                data_reg <= '0;
                mask_reg <= '0;
                cnt_reg  <= '0;
            end else if (accept) begin
                data_reg <= (data_reg & ~bit_hit) | (bit_val & bit_hit);
                mask_reg <= (mask_reg & ~bit_hit) | ({RESP_W{unstable}} & bit_hit);
                ptr_reg  <= ptr_sum;
                cnt_reg  <= cnt_reg + CW'(unstable);
                if (ptr_reg == '0) begin
                    mode_reg <= mode;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && (ptr_sum == PW'(RESP_W))) state_next = HOLD;
            HOLD:    if (resp_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        in_ready   = (state_reg == COLLECT);
        resp_valid = (state_reg == HOLD);
    end

    assign resp_data    = data_reg;
    assign resp_mask    = mask_reg;
    assign unstable_cnt = cnt_reg;

endmodule
